rojo_io_port: RTL and testbench
===============================

ROJO_IO_PORT -- requirements
Module: rojo_io_port

Interface
REQ-001 Parameter PORT_WIDTH, default 8, width of in_port/out_port/data buses.
REQ-002 Parameter PORT_DEPTH, default 8, width of port_id.
REQ-003 Parameter BASE_ADDR, default 8'h00, base port_id of the 4-register window, aligned to 4.
REQ-004 Parameter RX_DEPTH, default 8, RX FIFO entries, power of 2, at least 2.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 port_id  input  PORT_DEPTH  processor port address.
REQ-008 write_strobe  input  1  processor write qualifier, one cycle.
REQ-009 read_strobe  input  1  processor read qualifier, one cycle.
REQ-010 out_port  input  PORT_WIDTH  processor write data.
REQ-011 in_port  output  PORT_WIDTH  processor read data.
REQ-012 interrupt  output  1  interrupt request to processor.
REQ-013 interrupt_ack  input  1  processor interrupt acknowledge, one cycle.
REQ-014 rx_valid / rx_data  input  1 / PORT_WIDTH  external byte offered to RX FIFO.
REQ-015 rx_ready  output  1  high when RX FIFO not full.
REQ-016 tx_valid / tx_data  output  1 / PORT_WIDTH  byte offered to external sink.
REQ-017 tx_ready  input  1  external sink accepts tx_data.

Function
REQ-018 Offsets from BASE_ADDR: 0 STATUS (R), 1 RX_DATA (R, pops FIFO), 2 TX_DATA (W), 3 IRQ_EN (R/W, bit 0 used); port_id outside window is ignored, in_port=0.
REQ-019 STATUS bits: [0] rx_empty, [1] rx_full, [2] tx_valid, [3] rx_overflow sticky, [4] rx_underflow sticky, others 0.
REQ-020 in_port is registered: each cycle it loads the decode of current port_id, so data is valid one cycle after port_id is presented.
REQ-021 RX_DATA in_port shows FIFO head (0 when empty); pop occurs on read_strobe with port_id=RX_DATA.
REQ-022 Read_strobe on STATUS clears bits 3 and 4 after the cycle; an event in the same cycle keeps the bit set.
REQ-023 Push occurs when rx_valid and rx_ready; simultaneous push and pop when full or empty both succeed, count unchanged when full, count 1 with pushed byte when empty.
REQ-024 rx_valid while full drops the byte and sets rx_overflow; pop while empty leaves pointers unchanged and sets rx_underflow.
REQ-025 Pointers wrap modulo RX_DEPTH; count held in log2(RX_DEPTH)+1 bits.
REQ-026 TX holding register: TX states IDLE and SEND; write_strobe to TX_DATA in IDLE loads tx_data, moves to SEND with tx_valid=1; tx_valid and tx_ready returns to IDLE next cycle.
REQ-027 Write to TX_DATA in SEND is discarded, tx_data held stable until accepted.
REQ-028 Interrupt FSM states IDLE, REQ: IDLE to REQ when IRQ_EN[0]=1 and a push occurs; REQ holds interrupt=1 until interrupt_ack, then IDLE.
REQ-029 Clearing IRQ_EN[0] while in REQ forces IDLE next cycle; push plus interrupt_ack in the same cycle in REQ returns to IDLE (no re-arm).

Reset
REQ-030 reset asserts asynchronously: in_port=0, interrupt=0, tx_valid=0, tx_data=0, FIFO empty (rx_ready=1), sticky bits 0, IRQ_EN=0, both FSMs IDLE.
REQ-031 Reset mid-transfer discards the pending TX byte and all FIFO contents; no strobe is honored while reset is high.

Configuration
REQ-032 Macro ROJO_IO_IRQ_EN defined: interrupt FSM and IRQ_EN register are present per REQ-028/029.
REQ-033 ROJO_IO_IRQ_EN undefined: interrupt tied 0, interrupt_ack ignored, IRQ_EN reads 0 and writes are ignored; all other behaviour is identical.

Verification
REQ-034 Reset, then read STATUS -> in_port=8'h01, rx_ready=1, interrupt=0.
REQ-035 Push 8'hA5, 8'h3C; two RX_DATA reads -> in_port 8'hA5 then 8'h3C; STATUS then 8'h01.
REQ-036 Push 9 bytes with RX_DEPTH=8 -> 9th dropped, STATUS=8'h0A; STATUS read, then STATUS=8'h02.
REQ-037 Write 8'h5A to TX_DATA with tx_ready=0 for 3 cycles, write 8'hFF, then tx_ready=1 -> tx_data=8'h5A throughout, one transfer, 8'hFF lost.
REQ-038 IRQ_EN=1, push 8'h11 -> interrupt=1 next cycle, held until interrupt_ack pulse, then 0; with ROJO_IO_IRQ_EN undefined interrupt stays 0.
REQ-039 Full FIFO, simultaneous push 8'h77 and RX_DATA pop -> count stays 8, no overflow flag, 8'h77 read last.

Source files
------------

// File: rtl/rojo_io_port.sv
// rojo_io_port: 4-register processor I/O window with RX FIFO, TX holding register and optional interrupt FSM.
// Define ROJO_IO_IRQ_EN to include the IRQ_EN register and interrupt FSM.
module rojo_io_port #(
  parameter int PORT_WIDTH = 8,
  parameter int PORT_DEPTH = 8,
  parameter logic [PORT_DEPTH-1:0] BASE_ADDR = '0,
  parameter int RX_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PORT_DEPTH-1:0] port_id,
  input  logic                  write_strobe,
  input  logic                  read_strobe,
  input  logic [PORT_WIDTH-1:0] out_port,
  output logic [PORT_WIDTH-1:0] in_port,
  output logic                  interrupt,
  input  logic                  interrupt_ack,
  input  logic                  rx_valid,
  input  logic [PORT_WIDTH-1:0] rx_data,
  output logic                  rx_ready,
  output logic                  tx_valid,
  output logic [PORT_WIDTH-1:0] tx_data,
  input  logic                  tx_ready
);
  localparam int AW = $clog2(RX_DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(RX_DEPTH);
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
  logic                  sel;
  logic [1:0]            off;
  logic                  empty, full, pop_req, push, pop, stat_clr, tx_wr;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]           cnt_q, cnt_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic [PORT_WIDTH-1:0] in_port_q, in_port_d, tx_data_q, tx_data_d;
  logic [PORT_WIDTH-1:0] rd_status, rd_head, rd_irq;
  logic [PORT_WIDTH-1:0] mem_q [RX_DEPTH];
  tx_state_t             tx_q, tx_d;

  assign sel      = port_id[PORT_DEPTH-1:2] == BASE_ADDR[PORT_DEPTH-1:2];
  assign off      = port_id[1:0];
  assign empty    = cnt_q == '0;
  assign full     = cnt_q == CNT_FULL;
  assign pop_req  = read_strobe && sel && off == 2'd1;
  assign stat_clr = read_strobe && sel && off == 2'd0;
  assign tx_wr    = write_strobe && sel && off == 2'd2;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign push     = rx_valid && (!full || pop_req);
  assign pop      = pop_req && !empty;
  assign rx_ready = !full;
  assign tx_valid = tx_q == TX_SEND;
  assign tx_data  = tx_data_q;
  assign in_port  = in_port_q;

  always_comb begin
    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d     = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    ovf_d     = (ovf_q && !stat_clr) || (rx_valid && full && !pop_req);
    unf_d     = (unf_q && !stat_clr) || (pop_req && empty && !push);
    rd_status = {{(PORT_WIDTH-5){1'b0}}, unf_q, ovf_q, tx_valid, full, empty};
    rd_head   = empty ? '0 : mem_q[rd_ptr_q];
    in_port_d = !sel ? '0 :
                off == 2'd0 ? rd_status :
                off == 2'd1 ? rd_head :
                off == 2'd3 ? rd_irq : '0;
    tx_d      = tx_q == TX_IDLE ? (tx_wr ? TX_SEND : TX_IDLE) : (tx_ready ? TX_IDLE : TX_SEND);
    tx_data_d = (tx_q == TX_IDLE && tx_wr) ? out_port : tx_data_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      in_port_q <= '0;
      tx_data_q <= '0;
      tx_q      <= TX_IDLE;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      in_port_q <= in_port_d;
      tx_data_q <= tx_data_d;
      tx_q      <= tx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rx_data;
  end

`ifdef ROJO_IO_IRQ_EN
  typedef enum logic {IRQ_IDLE, IRQ_REQ} irq_state_t;
  irq_state_t irq_q, irq_d;
  logic       irq_en_q, irq_en_d;

  // Clearing the enable drops a pending request on the same edge that stores it.
  always_comb begin
    irq_en_d = (write_strobe && sel && off == 2'd3) ? out_port[0] : irq_en_q;
    irq_d    = irq_q == IRQ_IDLE ? ((irq_en_q && push) ? IRQ_REQ : IRQ_IDLE)
                                 : ((interrupt_ack || !irq_en_d) ? IRQ_IDLE : IRQ_REQ);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q    <= IRQ_IDLE;
      irq_en_q <= 1'b0;
    end else begin
      irq_q    <= irq_d;
      irq_en_q <= irq_en_d;
    end
  end

  assign interrupt = irq_q == IRQ_REQ;
  assign rd_irq    = {{(PORT_WIDTH-1){1'b0}}, irq_en_q};
`else
  logic unused_ack;
  assign unused_ack = interrupt_ack;
  assign interrupt  = 1'b0;
  assign rd_irq     = '0;
`endif
endmodule

// File: tb/tb_rojo_io_port.sv
// tb_rojo_io_port: directed and randomized checks of rojo_io_port against a queue-based model.
module tb_rojo_io_port;
`ifdef ROJO_IO_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] port_id = '0;
  logic       write_strobe = 1'b0, read_strobe = 1'b0;
  logic [7:0] out_port = '0;
  logic [7:0] in_port;
  logic       interrupt;
  logic       interrupt_ack = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  int xfers = 0;

  logic [7:0] m_q[$];
  logic [7:0] m_in, m_tx;
  logic       m_ovf, m_unf, m_busy, m_en, m_irq;

  rojo_io_port dut (
    .clk(clk), .reset(reset), .port_id(port_id), .write_strobe(write_strobe),
    .read_strobe(read_strobe), .out_port(out_port), .in_port(in_port),
    .interrupt(interrupt), .interrupt_ack(interrupt_ack), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_ready(rx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (!reset && tx_valid && tx_ready) xfers++;

  task automatic model_reset();
    m_q.delete();
    m_in = '0; m_tx = '0;
    m_ovf = 1'b0; m_unf = 1'b0; m_busy = 1'b0; m_en = 1'b0; m_irq = 1'b0;
  endtask

  // One clock of the register-window rules, using the inputs as they stand before the edge.
  task automatic model_step();
    logic sel, pop_r, clr, acc, new_en;
    logic [1:0] off;
    int n;
    if (reset) begin
      model_reset();
      return;
    end
    sel = port_id[7:2] == 6'd0;
    off = port_id[1:0];
    n = m_q.size();
    pop_r = read_strobe && sel && off == 2'd1;
    clr = read_strobe && sel && off == 2'd0;
    acc = rx_valid && (n < 8 || pop_r);
    m_in = !sel ? 8'h00 :
           off == 2'd0 ? {3'b000, m_unf, m_ovf, m_busy, n == 8, n == 0} :
           off == 2'd1 ? (n > 0 ? m_q[0] : 8'h00) :
           off == 2'd3 ? {7'b0, m_en} : 8'h00;
    m_ovf = (m_ovf && !clr) || (rx_valid && n == 8 && !pop_r);
    m_unf = (m_unf && !clr) || (pop_r && n == 0 && !rx_valid);
    if (pop_r && n > 0) void'(m_q.pop_front());
    if (acc) m_q.push_back(rx_data);
    if (m_busy) begin
      if (tx_ready) m_busy = 1'b0;
    end else if (write_strobe && sel && off == 2'd2) begin
      m_busy = 1'b1;
      m_tx = out_port;
    end
    new_en = (IRQ && write_strobe && sel && off == 2'd3) ? out_port[0] : m_en;
    if (m_irq) begin
      if (interrupt_ack || !new_en) m_irq = 1'b0;
    end else if (m_en && acc) m_irq = 1'b1;
    m_en = new_en;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write_strobe = 1'b0; read_strobe = 1'b0; rx_valid = 1'b0; interrupt_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    tick(); tick();
    checks++; if ({in_port, rx_ready, interrupt, tx_valid, tx_data} !== {8'h00, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      errors++; $display("FAIL reset_outputs got=%h exp=%h", {in_port, rx_ready, interrupt, tx_valid, tx_data}, {8'h00, 1'b1, 1'b0, 1'b0, 8'h00}); end
    reset = 1'b0;
    port_id = 8'h00;
    tick();
    checks++; if ({in_port, rx_ready, interrupt} !== {8'h01, 1'b1, 1'b0}) begin
      errors++; $display("FAIL reset_status got=%h exp=%h", {in_port, rx_ready, interrupt}, {8'h01, 1'b1, 1'b0}); end
  endtask

  task automatic test_rx_order();
    rx_valid = 1'b1; rx_data = 8'hA5; tick();
    rx_data = 8'h3C; tick();
    rx_valid = 1'b0; port_id = 8'h01; read_strobe = 1'b1; tick();
    checks++; if (in_port !== 8'hA5) begin errors++; $display("FAIL rx_first got=%h exp=%h", in_port, 8'hA5); end
    tick();
    checks++; if (in_port !== 8'h3C) begin errors++; $display("FAIL rx_second got=%h exp=%h", in_port, 8'h3C); end
    read_strobe = 1'b0; port_id = 8'h00; tick();
    checks++; if (in_port !== 8'h01) begin errors++; $display("FAIL rx_drained got=%h exp=%h", in_port, 8'h01); end
  endtask

  task automatic test_overflow();
    rx_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin rx_data = 8'h80 + 8'(i); tick(); end
    rx_valid = 1'b0;
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL ovf_ready got=%b exp=0", rx_ready); end
    port_id = 8'h00; read_strobe = 1'b1; tick();
    checks++; if (in_port !== 8'h0A) begin errors++; $display("FAIL ovf_status got=%h exp=%h", in_port, 8'h0A); end
    read_strobe = 1'b0; tick();
    checks++; if (in_port !== 8'h02) begin errors++; $display("FAIL ovf_cleared got=%h exp=%h", in_port, 8'h02); end
    port_id = 8'h01; read_strobe = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (in_port !== 8'h80 + 8'(i)) begin errors++; $display("FAIL ovf_drain%0d got=%h exp=%h", i, in_port, 8'h80 + 8'(i)); end
    end
    read_strobe = 1'b0;
  endtask

  task automatic test_underflow();
    port_id = 8'h01; read_strobe = 1'b1; tick();
    checks++; if (in_port !== 8'h00) begin errors++; $display("FAIL unf_data got=%h exp=00", in_port); end
    read_strobe = 1'b0; port_id = 8'h00; tick();
    checks++; if (in_port !== 8'h11) begin errors++; $display("FAIL unf_status got=%h exp=%h", in_port, 8'h11); end
    read_strobe = 1'b1; tick();
    checks++; if (in_port !== 8'h11) begin errors++; $display("FAIL unf_clear_read got=%h exp=%h", in_port, 8'h11); end
    read_strobe = 1'b0; tick();
    checks++; if (in_port !== 8'h01) begin errors++; $display("FAIL unf_cleared got=%h exp=%h", in_port, 8'h01); end
  endtask

  task automatic test_window();
    rx_valid = 1'b1; rx_data = 8'hAB; tick();
    rx_valid = 1'b0; port_id = 8'h41; read_strobe = 1'b1; tick();
    checks++; if (in_port !== 8'h00) begin errors++; $display("FAIL win_read got=%h exp=00", in_port); end
    read_strobe = 1'b0; port_id = 8'h42; write_strobe = 1'b1; out_port = 8'h99; tick();
    write_strobe = 1'b0; port_id = 8'h00; tick();
    checks++; if ({in_port, tx_valid} !== {8'h00, 1'b0}) begin errors++; $display("FAIL win_status got=%h exp=%h", {in_port, tx_valid}, 9'h000); end
    port_id = 8'h01; read_strobe = 1'b1; tick();
    checks++; if (in_port !== 8'hAB) begin errors++; $display("FAIL win_kept got=%h exp=%h", in_port, 8'hAB); end
    read_strobe = 1'b0;
  endtask

  task automatic test_tx();
    int x0;
    tx_ready = 1'b0; port_id = 8'h02; write_strobe = 1'b1; out_port = 8'h5A; tick();
    write_strobe = 1'b0;
    checks++; if ({tx_valid, tx_data} !== {1'b1, 8'h5A}) begin errors++; $display("FAIL tx_load got=%h exp=%h", {tx_valid, tx_data}, {1'b1, 8'h5A}); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({tx_valid, tx_data} !== {1'b1, 8'h5A}) begin errors++; $display("FAIL tx_hold%0d got=%h exp=%h", i, {tx_valid, tx_data}, {1'b1, 8'h5A}); end
    end
    write_strobe = 1'b1; out_port = 8'hFF; tick();
    write_strobe = 1'b0;
    checks++; if ({tx_valid, tx_data} !== {1'b1, 8'h5A}) begin errors++; $display("FAIL tx_discard got=%h exp=%h", {tx_valid, tx_data}, {1'b1, 8'h5A}); end
    x0 = xfers;
    tx_ready = 1'b1; tick();
    checks++; if ({tx_valid, tx_data} !== {1'b0, 8'h5A}) begin errors++; $display("FAIL tx_done got=%h exp=%h", {tx_valid, tx_data}, {1'b0, 8'h5A}); end
    tick(); tick();
    checks++; if (xfers - x0 !== 1 || tx_valid !== 1'b0) begin errors++; $display("FAIL tx_count got=%0d/%b exp=1/0", xfers - x0, tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_irq();
    port_id = 8'h03; write_strobe = 1'b1; out_port = 8'h01; tick();
    write_strobe = 1'b0; tick();
    checks++; if (in_port !== {7'b0, IRQ}) begin errors++; $display("FAIL irq_en_read got=%h exp=%h", in_port, {7'b0, IRQ}); end
    rx_valid = 1'b1; rx_data = 8'h11; tick();
    rx_valid = 1'b0;
    checks++; if (interrupt !== IRQ) begin errors++; $display("FAIL irq_raise got=%b exp=%b", interrupt, IRQ); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (interrupt !== IRQ) begin errors++; $display("FAIL irq_hold%0d got=%b exp=%b", i, interrupt, IRQ); end
    end
    interrupt_ack = 1'b1; tick();
    interrupt_ack = 1'b0;
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL irq_ack got=%b exp=0", interrupt); end
    rx_valid = 1'b1; rx_data = 8'h22; tick();
    rx_valid = 1'b0;
    checks++; if (interrupt !== IRQ) begin errors++; $display("FAIL irq_raise2 got=%b exp=%b", interrupt, IRQ); end
    write_strobe = 1'b1; out_port = 8'h00; tick();
    write_strobe = 1'b0;
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL irq_disable got=%b exp=0", interrupt); end
    write_strobe = 1'b1; out_port = 8'h01; tick();
    write_strobe = 1'b0; rx_valid = 1'b1; rx_data = 8'h33; tick();
    interrupt_ack = 1'b1; rx_data = 8'h44; tick();
    interrupt_ack = 1'b0; rx_valid = 1'b0; tick();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL irq_no_rearm got=%b exp=0", interrupt); end
    write_strobe = 1'b1; out_port = 8'h00; tick();
    write_strobe = 1'b0; port_id = 8'h01; read_strobe = 1'b1;
    for (int i = 0; i < 10 && m_q.size() > 0; i++) begin
      tick();
      checks++; if (in_port !== m_in) begin errors++; $display("FAIL irq_drain%0d got=%h exp=%h", i, in_port, m_in); end
    end
    read_strobe = 1'b0;
  endtask

  task automatic test_full_simul();
    logic [7:0] e;
    rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin rx_data = 8'(i * 17 + 1); tick(); end
    port_id = 8'h01; read_strobe = 1'b1; rx_data = 8'h77; tick();
    rx_valid = 1'b0; read_strobe = 1'b0;
    checks++; if ({in_port, rx_ready} !== {8'h01, 1'b0}) begin errors++; $display("FAIL full_pop got=%h exp=%h", {in_port, rx_ready}, {8'h01, 1'b0}); end
    port_id = 8'h00; tick();
    checks++; if (in_port !== 8'h02) begin errors++; $display("FAIL full_status got=%h exp=%h", in_port, 8'h02); end
    port_id = 8'h01; read_strobe = 1'b1;
    for (int i = 0; i < 8; i++) begin
      e = i < 7 ? 8'((i + 1) * 17 + 1) : 8'h77;
      tick();
      checks++; if (in_port !== e) begin errors++; $display("FAIL full_drain%0d got=%h exp=%h", i, in_port, e); end
    end
    read_strobe = 1'b0; port_id = 8'h00; tick();
    checks++; if (in_port !== 8'h01) begin errors++; $display("FAIL full_empty got=%h exp=%h", in_port, 8'h01); end
  endtask

  task automatic test_reset_mid();
    rx_valid = 1'b1; rx_data = 8'hC1; tick();
    rx_data = 8'hC2; tick();
    rx_valid = 1'b0; tx_ready = 1'b0; port_id = 8'h02; write_strobe = 1'b1; out_port = 8'h42; tick();
    write_strobe = 1'b0;
    checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL mid_pending got=%b exp=1", tx_valid); end
    reset = 1'b1; write_strobe = 1'b1; rx_valid = 1'b1; read_strobe = 1'b0;
    #2;
    checks++; if ({in_port, tx_valid, tx_data, rx_ready, interrupt} !== {8'h00, 1'b0, 8'h00, 1'b1, 1'b0}) begin
      errors++; $display("FAIL mid_async got=%h exp=%h", {in_port, tx_valid, tx_data, rx_ready, interrupt}, {8'h00, 1'b0, 8'h00, 1'b1, 1'b0}); end
    tick();
    checks++; if ({tx_valid, rx_ready} !== 2'b01) begin errors++; $display("FAIL mid_strobes got=%b exp=01", {tx_valid, rx_ready}); end
    reset = 1'b0; idle(); port_id = 8'h00; tick();
    checks++; if (in_port !== 8'h01) begin errors++; $display("FAIL mid_after got=%h exp=%h", in_port, 8'h01); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      port_id = 8'($urandom_range(0, 5));
      read_strobe = ($urandom % 3) == 0;
      write_strobe = !read_strobe && ($urandom % 4) == 0;
      out_port = 8'($urandom);
      rx_valid = ($urandom % 2) == 0;
      rx_data = 8'($urandom);
      tx_ready = ($urandom % 3) != 0;
      interrupt_ack = ($urandom % 6) == 0;
      tick();
      checks++;
      if ({in_port, rx_ready, tx_valid, tx_data, interrupt} !== {m_in, m_q.size() < 8, m_busy, m_tx, m_irq}) begin
        errors++;
        $display("FAIL rand%0d got=%h exp=%h", i, {in_port, rx_ready, tx_valid, tx_data, interrupt}, {m_in, m_q.size() < 8, m_busy, m_tx, m_irq});
      end
    end
    idle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rx_order();
    test_overflow();
    test_underflow();
    test_window();
    test_tx();
    test_irq();
    test_full_simul();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
